mul_arbiter: RTL and testbench
==============================

// Module: mul_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one sequential signed multiplier (go/done,
//  ain, pin -> p) among NREQ requesters. Latches the winner's operands, drives go,
//  waits for done, returns the 2W-bit product with a one-cycle ack to the winner.
//  Sits between client blocks and the single multiplier instance in top-level designs.
// PARAMETERS
//  W        8     operand width (signed, two's complement); product is 2*W
//  NREQ     4     number of requesters (2..8)
//  TIMEOUT  255   max cycles in WAIT before aborting with err (must be >= 1)
// PORTS
//  clk      in   1          rising-edge clock
//  rstn     in   1          synchronous active-low reset
//  req      in   NREQ       level request per client; held until its ack
//  a_in     in   NREQ*W     client i multiplicand at [i*W +: W]
//  b_in     in   NREQ*W     client i multiplier at [i*W +: W]
//  ack      out  NREQ       one-cycle pulse to the served client (one-hot or zero)
//  err      out  1          pulses with ack when the operation timed out
//  result   out  2*W        product for the acked client; held until next ack
//  busy     out  1          high in every state except IDLE
//  mul_go   out  1          to multiplier go
//  mul_a    out  W          to multiplier ain
//  mul_b    out  W          to multiplier pin
//  mul_p    in   2*W        from multiplier p
//  mul_done in   1          from multiplier done
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE; ack=0, err=0, result=0, busy=0, mul_go=0,
//   mul_a=0, mul_b=0, last grant pointer = NREQ-1 (so client 0 wins first).
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> RELEASE -> IDLE.
//  IDLE: if |req, pick first set req scanning from (last+1) mod NREQ upward with wrap;
//   latch its a/b into mul_a/mul_b, record index, set last=index -> ISSUE. Else stay.
//  ISSUE: mul_go=1 (one cycle of stable operands before go) -> WAIT; clear timer.
//  WAIT: mul_go held 1. On mul_done=1: result<=mul_p -> DONE. Timer increments each
//   cycle; when timer==TIMEOUT without done: result<=0, flag err -> DONE.
//  DONE: mul_go=0; ack[index]=1 for exactly this cycle; err=1 this cycle iff timed out
//   -> RELEASE.
//  RELEASE: mul_go=0; stay until mul_done=0 (return-to-zero), then -> IDLE.
//  Latency: req seen in IDLE -> ack = 3 + multiplier cycles (go-to-done) + 0 extra.
//  Operands/req changes after latching are ignored; a withdrawn req still gets its ack.
//  req dropped before being sampled in IDLE = never served. No request is granted while
//   busy; new reqs wait. Same client requesting back-to-back yields to any other
//   pending client (fairness: any pending client served within NREQ grants).
//  mul_a/mul_b stay at last latched values outside ISSUE/WAIT (no re-zeroing).
//  Reset mid-operation aborts silently: no ack, mul_go drops the next cycle.
//  result is the multiplier's raw 2W-bit signed product; no width conversion here.
// TESTING
//  1 Single: req=0001, a0=20, b0=-10 -> mul_go high until done; ack=0001 one cycle,
//    result=16'hFF38 (-200), err=0, busy low after RELEASE.
//  2 Signs: client2 a=-10, b=-60 -> result=16'h0258 (600); client3 a=25,b=40 -> 16'h03E8.
//  3 Round-robin: req=1111 held, distinct operands -> acks in order 0,1,2,3,0; each
//    result matches its client; mul_go low >=1 cycle between operations.
//  4 Hog: req=0011 with client0 re-requesting at once -> grants alternate 0,1,0,1.
//  5 Timeout (TIMEOUT=10, mul_done tied 0) -> ack+err after 10 WAIT cycles, result=0;
//    FSM then returns to IDLE once mul_done=0.
//  6 Reset in WAIT: rstn=0 one cycle -> next cycle mul_go=0, busy=0, no ack; next
//    grant goes to client 0.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Bundle between mul_arbiter, its requesting clients and the shared sequential multiplier.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mul_arbiter_if #(
    parameter int W    = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]          req;
    logic [NREQ*W-1:0]        a_in;
    logic [NREQ*W-1:0]        b_in;
    logic [NREQ-1:0]          ack;
    logic                     err;
    logic signed [2*W-1:0]    result;
    logic                     busy;
    logic                     mul_go;
    logic signed [W-1:0]      mul_a;
    logic signed [W-1:0]      mul_b;
    logic signed [2*W-1:0]    mul_p;
    logic                     mul_done;

    modport slave (
        input  req, a_in, b_in, mul_p, mul_done,
        output ack, err, result, busy, mul_go, mul_a, mul_b
    );

    modport master (
        output req, a_in, b_in, mul_p, mul_done,
        input  ack, err, result, busy, mul_go, mul_a, mul_b
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one go/done signed multiplier among NREQ clients.
// Operands are latched at grant; the product comes back with a one-cycle ack to the winner.
module mul_arbiter #(
    parameter int W       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rstn,
    mul_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RELEASE} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            pick_vld;
    logic [TW-1:0]   timer;

    // Scan starts just past the previous winner so a re-requesting client yields to others.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!pick_vld && bus.req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            bus.ack    <= '0;
            bus.err    <= 1'b0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.mul_go <= 1'b0;
            bus.mul_a  <= '0;
            bus.mul_b  <= '0;
            last       <= IW'(NREQ - 1);
            idx        <= '0;
            timer      <= '0;
        end else begin
            bus.ack <= '0;
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        bus.mul_a <= bus.a_in[int'(pick)*W +: W];
                        bus.mul_b <= bus.b_in[int'(pick)*W +: W];
                        idx       <= pick;
                        last      <= pick;
                        bus.busy  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mul_go <= 1'b1;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // ack/err are registered, so they are raised on the edge entering DONE.
                    if (bus.mul_done) begin
                        bus.result   <= bus.mul_p;
                        bus.ack[idx] <= 1'b1;
                        bus.mul_go   <= 1'b0;
                        state        <= DONE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.result   <= '0;
                        bus.err      <= 1'b1;
                        bus.ack[idx] <= 1'b1;
                        bus.mul_go   <= 1'b0;
                        state        <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!bus.mul_done) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a go/done multiplier model and an ack scoreboard.
module tb_mul_arbiter;
    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int TOUT = 10;
    localparam int MLAT = 3;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic kill = 1'b0;
    logic mdone = 1'b0;
    logic [15:0] mprod = '0;
    int   mcnt = 0;
    int   tests = 0;
    int   fails = 0;
    int   ack_cnt = 0;
    int   gocnt = 0;
    exp_t sb[$];

    mul_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

    mul_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Sequential multiplier: done rises MLAT clocks after go is seen, drops once go falls.
    always @(posedge clk) begin
        if (!bus.mul_go || kill) begin
            mdone <= 1'b0;
            mcnt  <= 0;
        end else if (!mdone) begin
            if (mcnt == MLAT - 1) begin
                mdone <= 1'b1;
                mprod <= {{W{bus.mul_a[W-1]}}, bus.mul_a} * {{W{bus.mul_b[W-1]}}, bus.mul_b};
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end
    assign bus.mul_done = mdone;
    assign bus.mul_p    = mprod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input int a, input int b, input logic e);
        exp_t x;
        x.idx = idx;
        x.res = e ? 16'h0000 : 16'(a * b);
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        bus.a_in[i*W +: W] = 8'(a);
        bus.b_in[i*W +: W] = 8'(b);
    endtask

    task automatic wait_acks(input int target, input int budget);
        gocnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.mul_go) gocnt++;
            if (ack_cnt >= target) break;
        end
        chk("ack_arrived", 32'(ack_cnt >= target), 32'd1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: every ack pops the next expected grant.
    always @(negedge clk) begin
        if (rstn && bus.ack != '0) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                chk("ack_unexpected", 32'(bus.ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_onehot", 32'(bus.ack), 32'(1) << e.idx);
                chk("result", 32'($unsigned(bus.result)), 32'(e.res));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("go_low_at_ack", 32'(bus.mul_go), 32'd0);
            end
        end
    end

    initial begin
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        tick(3);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_result", 32'($unsigned(bus.result)), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_go", 32'(bus.mul_go), 32'd0);
        chk("rst_mul_a", 32'($unsigned(bus.mul_a)), 32'd0);
        chk("rst_mul_b", 32'($unsigned(bus.mul_b)), 32'd0);
        rstn = 1'b1;
        tick(1);

        // Single client 0: 20 * -10 = -200.
        set_ops(0, 20, -10);
        push(0, 20, -10, 1'b0);
        bus.req = 4'b0001;
        wait_acks(1, 100);
        chk("single_go_cycles", 32'(gocnt), 32'(MLAT + 1));
        chk("single_value", 32'(sb.size()), 32'd0);
        bus.req = 4'b0000;
        tick(3);
        chk("single_busy_low", 32'(bus.busy), 32'd0);

        // Client 2 with operands changed after latching, then client 3.
        set_ops(2, -10, -60);
        push(2, -10, -60, 1'b0);
        bus.req = 4'b0100;
        tick(2);
        chk("busy_after_grant", 32'(bus.busy), 32'd1);
        set_ops(2, 99, 99);
        wait_acks(2, 100);
        bus.req = 4'b0000;
        set_ops(3, 25, 40);
        push(3, 25, 40, 1'b0);
        bus.req = 4'b1000;
        wait_acks(3, 100);
        bus.req = 4'b0000;
        tick(3);

        // Round-robin with all four held.
        set_ops(0, 3, 4);
        set_ops(1, -5, 6);
        set_ops(2, 7, -8);
        set_ops(3, -9, -10);
        push(0, 3, 4, 1'b0);
        push(1, -5, 6, 1'b0);
        push(2, 7, -8, 1'b0);
        push(3, -9, -10, 1'b0);
        push(0, 3, 4, 1'b0);
        bus.req = 4'b1111;
        wait_acks(8, 300);
        bus.req = 4'b0000;
        tick(4);
        chk("rr_drained", 32'(sb.size()), 32'd0);

        // Reset while waiting on the multiplier.
        set_ops(2, 7, 3);
        bus.req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.mul_go) break;
        end
        chk("rst_wait_go_high", 32'(bus.mul_go), 32'd1);
        rstn = 1'b0;
        bus.req = 4'b0000;
        tick(1);
        chk("midrst_go", 32'(bus.mul_go), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        rstn = 1'b1;
        tick(6);
        chk("midrst_no_ack", 32'(ack_cnt), 32'd8);

        // Hog: 0 and 1 held, grants alternate starting at 0.
        set_ops(0, 11, -2);
        set_ops(1, -13, 3);
        push(0, 11, -2, 1'b0);
        push(1, -13, 3, 1'b0);
        push(0, 11, -2, 1'b0);
        push(1, -13, 3, 1'b0);
        bus.req = 4'b0011;
        wait_acks(12, 300);
        bus.req = 4'b0000;
        tick(4);
        chk("hog_drained", 32'(sb.size()), 32'd0);

        // Timeout with done tied low.
        kill = 1'b1;
        set_ops(1, 5, 5);
        push(1, 5, 5, 1'b1);
        bus.req = 4'b0010;
        wait_acks(13, 100);
        bus.req = 4'b0000;
        chk("tout_go_cycles", 32'(gocnt), 32'(TOUT));
        tick(3);
        chk("tout_idle", 32'(bus.busy), 32'd0);
        kill = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
